fp_add_pipe: RTL

Parametrised, pipelined IEEE-754 adder/subtractor. It is the sequential successor to the combinational single-precision adder.
- Generic exponent/mantissa widths, add/sub op select, five rounding modes.
- Full special-value handling and IEEE exception flags.
- Valid/ready handshake on both sides.
- Sits between the FPU operand dispatch and the result writeback arbiter.

---
 rtl/fp_add_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: pipelined IEEE-754 adder/subtractor with valid/ready handshake
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int FP_W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic             in_sub,
  input  logic [2:0]       in_rmode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_flags
);
  localparam int M = MAN_W + 4;
  localparam int SW = $clog2(M + 1);
  localparam int EW = EXP_W + 1;
  localparam logic [FP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             spec;
    logic             inv;
    logic [FP_W-1:0]  sres;
    logic             sign;
    logic             sub;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } side_t;

  logic             r0_valid, r1_valid, r2_valid, r3_valid, r4_valid;
  logic [FP_W-1:0]  r0_a, r0_b;
  logic             r0_sub;
  logic [2:0]       r0_rm;
  logic [TAG_W-1:0] r0_tag;
  side_t            r1_sd, r2_sd, r3_sd;
  logic [EXP_W-1:0] r1_exp, r2_exp;
  logic [M-1:0]     r1_ma, r1_mb, r3_man;
  logic [M:0]       r2_sum;
  logic [EW-1:0]    r3_exp;
  logic [FP_W-1:0]  r4_res;
  logic [TAG_W-1:0] r4_tag;
  logic [4:0]       r4_flags;

  logic w_adv;
  assign w_adv = !r4_valid || out_ready;
  assign in_ready = w_adv;
  assign out_valid = r4_valid;
  assign out_result = r4_res;
  assign out_tag = r4_tag;
  assign out_flags = r4_flags;

  logic             w_a_sgn, w_b_sgn, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_snan, w_b_snan;
  logic             w_swap, w_nan, w_ii;
  logic [EXP_W-1:0] w_a_exp, w_b_exp, w_big_exp, w_sml_exp, w_big_eff, w_sml_eff, w_diff;
  logic [MAN_W-1:0] w_a_frc, w_b_frc;
  logic [FP_W-1:0]  w_big, w_sml;
  logic [SW-1:0]    w_sh;
  logic [M-1:0]     w_ma, w_mb, w_sml_m;
  logic [2*M-1:0]   w_ext;
  side_t            w_sd1;

  assign w_a_sgn = r0_a[FP_W-1];
  assign w_b_sgn = r0_b[FP_W-1] ^ r0_sub;
  assign w_a_exp = r0_a[FP_W-2:MAN_W];
  assign w_b_exp = r0_b[FP_W-2:MAN_W];
  assign w_a_frc = r0_a[MAN_W-1:0];
  assign w_b_frc = r0_b[MAN_W-1:0];
  assign w_a_nan = (&w_a_exp) & (|w_a_frc);
  assign w_b_nan = (&w_b_exp) & (|w_b_frc);
  assign w_a_inf = (&w_a_exp) & ~(|w_a_frc);
  assign w_b_inf = (&w_b_exp) & ~(|w_b_frc);
  assign w_a_snan = w_a_nan & ~w_a_frc[MAN_W-1];
  assign w_b_snan = w_b_nan & ~w_b_frc[MAN_W-1];
  assign w_nan = w_a_nan | w_b_nan;
  assign w_ii = w_a_inf & w_b_inf & (w_a_sgn ^ w_b_sgn);
  // magnitude order of the raw exp|fraction fields matches numeric order
  assign w_swap = r0_b[FP_W-2:0] > r0_a[FP_W-2:0];
  assign w_big = w_swap ? {w_b_sgn, r0_b[FP_W-2:0]} : {w_a_sgn, r0_a[FP_W-2:0]};
  assign w_sml = w_swap ? {w_a_sgn, r0_a[FP_W-2:0]} : {w_b_sgn, r0_b[FP_W-2:0]};
  assign w_big_exp = w_big[FP_W-2:MAN_W];
  assign w_sml_exp = w_sml[FP_W-2:MAN_W];
  assign w_big_eff = (w_big_exp == '0) ? EXP_W'(1) : w_big_exp;
  assign w_sml_eff = (w_sml_exp == '0) ? EXP_W'(1) : w_sml_exp;
  assign w_diff = w_big_eff - w_sml_eff;
  assign w_sh = (32'(w_diff) > MAN_W + 3) ? SW'(MAN_W + 3) : SW'(w_diff);
  assign w_ma = {|w_big_exp, w_big[MAN_W-1:0], 3'b000};
  assign w_sml_m = {|w_sml_exp, w_sml[MAN_W-1:0], 3'b000};
  assign w_ext = {w_sml_m, {M{1'b0}}} >> w_sh;
  assign w_mb = w_ext[2*M-1:M] | {{(M-1){1'b0}}, |w_ext[M-1:0]};
  assign w_sd1 = '{
    spec: w_nan | w_a_inf | w_b_inf,
    inv:  w_a_snan | w_b_snan | w_ii,
    sres: (w_nan | w_ii) ? QNAN : w_a_inf ? {w_a_sgn, r0_a[FP_W-2:0]} : {w_b_sgn, r0_b[FP_W-2:0]},
    sign: w_big[FP_W-1],
    sub:  w_a_sgn ^ w_b_sgn,
    rm:   r0_rm,
    tag:  r0_tag
  };

  logic [M:0] w_sum;
  assign w_sum = r1_sd.sub ? {1'b0, r1_ma} - {1'b0, r1_mb} : {1'b0, r1_ma} + {1'b0, r1_mb};

  logic [SW-1:0]    w_lz, w_nsh;
  logic [EXP_W-1:0] w_em1;
  logic [M-1:0]     w_nman;
  logic [EW-1:0]    w_nexp;
  always_comb begin
    w_lz = SW'(M);
    for (int i = 0; i < M; i++) if (r2_sum[i]) w_lz = SW'(M - 1 - i);
  end
  assign w_em1 = r2_exp - EXP_W'(1);
  assign w_nsh = (32'(w_lz) < 32'(w_em1)) ? w_lz : SW'(w_em1);
  assign w_nman = r2_sum[M] ? {r2_sum[M:2], r2_sum[1] | r2_sum[0]} : r2_sum[M-1:0] << w_nsh;
  assign w_nexp = r2_sum[M] ? {1'b0, r2_exp} + EW'(1) : {1'b0, r2_exp} - EW'(w_nsh);

  logic             w_g, w_r, w_s, w_grs, w_sg, w_inc, w_ovf, w_inx, w_inf, w_zero, w_zsg;
  logic [2:0]       w_rm;
  logic [MAN_W+1:0] w_rnd;
  logic [EW-1:0]    w_rexp;
  logic [FP_W-1:0]  w_ores, w_res;
  logic [4:0]       w_flg;
  assign w_g = r3_man[2];
  assign w_r = r3_man[1];
  assign w_s = r3_man[0];
  assign w_grs = w_g | w_r | w_s;
  assign w_rm = r3_sd.rm;
  assign w_sg = r3_sd.sign;
  assign w_inc = (w_rm == 3'd1) ? 1'b0 :
                 (w_rm == 3'd2) ? w_grs & w_sg :
                 (w_rm == 3'd3) ? w_grs & ~w_sg :
                 (w_rm == 3'd4) ? w_g : w_g & (w_r | w_s | r3_man[3]);
  assign w_rnd = {1'b0, r3_man[M-1:3]} + (MAN_W+2)'(w_inc);
  // a tiny value that rounds up into the hidden bit becomes the smallest normal
  assign w_rexp = w_rnd[MAN_W+1] ? r3_exp + EW'(1) : w_rnd[MAN_W] ? r3_exp : '0;
  assign w_ovf = w_rexp >= EW'({EXP_W{1'b1}});
  assign w_inx = w_grs | w_ovf;
  assign w_inf = (w_rm == 3'd0) | (w_rm == 3'd4) | ((w_rm == 3'd3) & ~w_sg) | ((w_rm == 3'd2) & w_sg);
  assign w_ores = w_inf ? {w_sg, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {w_sg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  assign w_zero = ~|r3_man;
  assign w_zsg = (w_zero & r3_sd.sub) ? (w_rm == 3'd2) : w_sg;
  assign w_res = r3_sd.spec ? r3_sd.sres : w_ovf ? w_ores : {w_zsg, w_rexp[EXP_W-1:0], w_rnd[MAN_W-1:0]};
  assign w_flg = r3_sd.spec ? {r3_sd.inv, 4'b0000} : {1'b0, w_ovf, ~r3_man[M-1] & w_inx, w_inx, w_zero};

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
      r4_valid <= 1'b0;
      r4_res <= '0;
      r4_tag <= '0;
      r4_flags <= '0;
    end else if (w_adv) begin
      r0_valid <= in_valid;
      r0_a <= in_a;
      r0_b <= in_b;
      r0_sub <= in_sub;
      r0_rm <= (in_rmode > 3'd4) ? 3'd0 : in_rmode;
      r0_tag <= in_tag;
      r1_valid <= r0_valid;
      r1_sd <= w_sd1;
      r1_exp <= w_big_eff;
      r1_ma <= w_ma;
      r1_mb <= w_mb;
      r2_valid <= r1_valid;
      r2_sd <= r1_sd;
      r2_exp <= r1_exp;
      r2_sum <= w_sum;
      r3_valid <= r2_valid;
      r3_sd <= r2_sd;
      r3_exp <= w_nexp;
      r3_man <= w_nman;
      r4_valid <= r3_valid;
      r4_res <= w_res;
      r4_tag <= r3_sd.tag;
      r4_flags <= w_flg;
    end
  end
endmodule
